// File: rtl/rot_arb.sv
// ---------------------------------------------------------------------------
// rot_arb -- round-robin arbiter in front of a single shared barrel rotator.
//
// Up to NREQ requesters each offer an N-bit operand and a log2_N-bit rotate
// amount. In IDLE one requester is granted, round-robin from rr_ptr. Its
// operand is captured, rotated in ROT, and presented in OUT until the
// consumer accepts it. Only one transaction is in flight at a time.
//
// Bit numbering: the operand and result "index i" is the i-th bit from the
// left, i.e. vector bit N-1-i. The rotate-amount "index 0" is its MSB. A
// rotate toward higher index is therefore a right rotate of the vector.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      synchronous active-low reset
//   req_valid  [NREQ]          per-requester request
//   req_ready  [NREQ]          per-requester accept strobe (one-hot or zero)
//   req_bits   [NREQ*N]        operand of requester r at [r*N +: N]
//   req_k      [NREQ*log2_N]   rotate amount of requester r at [r*log2_N +: log2_N]
//   out_valid                  result valid
//   out_ready                  consumer accepts result
//   out_bits   [N]             rotated result
//   out_id     [IDW]           requester that owns out_bits
//   busy                       high whenever not in IDLE
// ---------------------------------------------------------------------------
module rot_arb #(
    parameter int N      = 2048,
    parameter int log2_N = 11,
    parameter int NREQ   = 4,
    parameter int IDW    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*N-1:0]      req_bits,
    input  logic [NREQ*log2_N-1:0] req_k,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N-1:0]           out_bits,
    output logic [IDW-1:0]         out_id,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [IDW-1:0]    rr_ptr;
    logic              grant_hit;
    logic [IDW-1:0]    grant_idx;
    logic [N-1:0]      held_bits;
    logic [log2_N-1:0] held_k;
    logic [IDW-1:0]    held_id;
    logic [N-1:0]      rot_result;

    // Unpack the flat request buses so the granted slice is a simple index.
    logic [N-1:0]      bits_arr [NREQ];
    logic [log2_N-1:0] k_arr    [NREQ];

    for (genvar r = 0; r < NREQ; r++) begin : g_unpack
        assign bits_arr[r] = req_bits[r*N +: N];
        assign k_arr[r]    = req_k[r*log2_N +: log2_N];
    end

    // Round-robin search: scan from the farthest candidate back toward
    // rr_ptr so the nearest set bit at/after rr_ptr wins.
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin : g_search
            logic [IDW:0]   cand;
            logic [IDW-1:0] cand_idx;
            cand = {1'b0, rr_ptr} + (IDW+1)'(j);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            cand_idx = cand[IDW-1:0];
            if (req_valid[cand_idx]) begin
                grant_hit = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    // Barrel rotator: stage s is steered by the s-th amount bit counted
    // from the MSB and rotates right by N >> (s+1).
    logic [N-1:0] stage [log2_N+1];
    assign stage[0] = held_bits;

    for (genvar s = 0; s < log2_N; s++) begin : g_rot
        localparam int SH = N >> (s + 1);
        assign stage[s+1] = held_k[log2_N-1-s] ? {stage[s][SH-1:0], stage[s][N-1:SH]}
                                               : stage[s];
    end
    assign rot_result = stage[log2_N];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and accept strobes. req_ready is also gated by rst_n so no
    // handshake can complete while reset is held.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (grant_hit) begin
                    state_nxt = ROT;
                    if (rst_n) begin
                        req_ready = NREQ'(1) << grant_idx;
                    end
                end
            end
            ROT:     state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Control and visible outputs: reset to known values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            out_valid <= 1'b0;
            out_bits  <= '0;
            out_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_hit) begin
                        rr_ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
                    end
                end
                ROT: begin
                    out_bits  <= rot_result;
                    out_id    <= held_id;
                    out_valid <= 1'b1;
                end
                OUT: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

    // NOTE: holding registers carry no reset; they are always written on a
    // grant before ROT reads them, so resetting them would only add fan-out.
    always_ff @(posedge clk) begin
        if (state == IDLE && grant_hit) begin
            held_bits <= bits_arr[grant_idx];
            held_k    <= k_arr[grant_idx];
            held_id   <= grant_idx;
        end
    end

endmodule

// File: tb/tb_rot_arb.sv
// ---------------------------------------------------------------------------
// tb_rot_arb -- directed self-checking bench for rot_arb (N=8, NREQ=4).
// Inputs change 1 time unit after the rising edge; outputs are checked one
// further unit later, well away from the edge.
// ---------------------------------------------------------------------------
module tb_rot_arb;

    localparam int N      = 8;
    localparam int LOG2N  = 3;
    localparam int NREQ   = 4;
    localparam int IDW    = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*N-1:0]     req_bits;
    logic [NREQ*LOG2N-1:0] req_k;
    logic                  out_valid;
    logic                  out_ready;
    logic [N-1:0]          out_bits;
    logic [IDW-1:0]        out_id;
    logic                  busy;

    int checks   = 0;
    int failures = 0;

    rot_arb #(.N(N), .log2_N(LOG2N), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_bits  (req_bits),
        .req_k     (req_k),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bits  (out_bits),
        .out_id    (out_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input logic [N-1:0] b, input logic [LOG2N-1:0] k);
        req_bits[r*N +: N]     = b;
        req_k[r*LOG2N +: LOG2N] = k;
    endtask

    // One transaction with out_ready high: handshake cycle t, ROT at t+1,
    // result at t+2, back in IDLE at t+3 (where this task returns).
    task automatic do_txn(input string tag, input int r, input logic [N-1:0] b,
                          input logic [LOG2N-1:0] k, input logic [N-1:0] exp_bits);
        set_req(r, b, k);
        req_valid = NREQ'(1) << r;
        out_ready = 1'b1;
        #1;
        check({tag, "_ready"}, 32'(req_ready), 32'(NREQ'(1) << r));
        tick();
        req_valid = '0;
        check({tag, "_rot_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_rot_busy"},  32'(busy),      32'd1);
        tick();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_bits"},  32'(out_bits),  32'(exp_bits));
        check({tag, "_id"},    32'(out_id),    32'(r));
        tick();
        check({tag, "_idle"},  32'(busy),      32'd0);
    endtask

    logic [N-1:0] rr_exp [4];

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_bits  = '0;
        req_k     = '0;
        out_ready = 1'b0;

        // Reset state; requests present but no strobe while in reset.
        tick();
        tick();
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_bits",  32'(out_bits),  32'd0);
        check("rst_id",    32'(out_id),    32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        req_valid = '0;
        rst_n     = 1'b1;
        tick();

        // Single transactions; rr_ptr moves 0 -> 1 -> 3 -> 3 -> 3.
        do_txn("r0_k1", 0, 8'b1000_0000, 3'b001, 8'b0100_0000);
        do_txn("r2_k4", 2, 8'b1100_0001, 3'b100, 8'b0001_1100);
        do_txn("r2_k7", 2, 8'b1100_0001, 3'b111, 8'b1000_0011);
        do_txn("r2_k0", 2, 8'b1100_0001, 3'b000, 8'b1100_0001);

        // Round-robin with all requesters continuously valid, from rr_ptr=0.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rr_exp[0] = 8'hA5;  // k=0
        rr_exp[1] = 8'hD2;  // k=1
        rr_exp[2] = 8'h69;  // k=2
        rr_exp[3] = 8'hB4;  // k=3
        for (int r = 0; r < NREQ; r++) set_req(r, 8'hA5, LOG2N'(r));
        req_valid = 4'b1111;
        out_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            #1;
            check($sformatf("rr%0d_ready", g), 32'(req_ready), 32'(4'b0001 << (g % 4)));
            tick();
            check($sformatf("rr%0d_rot_ready", g), 32'(req_ready), 32'd0);
            tick();
            check($sformatf("rr%0d_out_ready0", g), 32'(req_ready), 32'd0);
            check($sformatf("rr%0d_bits", g), 32'(out_bits), 32'(rr_exp[g % 4]));
            check($sformatf("rr%0d_id", g),   32'(out_id),   32'(g % 4));
            tick();
        end
        req_valid = '0;

        // Back-pressure in OUT; rr_ptr=1 so requester 1 is granted.
        set_req(1, 8'b0011_1100, 3'b010);
        req_valid = 4'b0010;
        out_ready = 1'b0;
        #1;
        check("bp_ready", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b1111;        // new requests while busy must be ignored
        set_req(1, 8'h00, 3'b000);  // operand change after capture must not matter
        tick();
        for (int i = 0; i < 6; i++) begin
            check($sformatf("bp%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d_bits", i),  32'(out_bits),  32'h0F);
            check($sformatf("bp%0d_id", i),    32'(out_id),    32'd1);
            check($sformatf("bp%0d_busy", i),  32'(busy),      32'd1);
            check($sformatf("bp%0d_ready", i), 32'(req_ready), 32'd0);
            if (i == 5) out_ready = 1'b1;
            tick();
        end
        check("bp_idle_busy",  32'(busy),      32'd0);
        check("bp_idle_valid", 32'(out_valid), 32'd0);
        check("bp_idle_ready", 32'(req_ready), 32'b0100);  // rr_ptr=2 now
        req_valid = '0;
        tick();

        // Reset during ROT discards the transaction and clears rr_ptr.
        set_req(1, 8'hFF, 3'b001);
        req_valid = 4'b0010;
        #1;
        check("rrot_ready", 32'(req_ready), 32'b0010);
        tick();
        check("rrot_busy", 32'(busy), 32'd1);
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        #1;
        check("rrot_ready_in_rst", 32'(req_ready), 32'd0);
        tick();
        rst_n     = 1'b1;
        req_valid = '0;
        check("rrot_valid", 32'(out_valid), 32'd0);
        check("rrot_busy0", 32'(busy),      32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rrot_stale%0d", i), 32'(out_valid), 32'd0);
        end
        req_valid = 4'b1111;
        #1;
        check("rrot_ptr0", 32'(req_ready), 32'b0001);
        req_valid = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rot_arb.md
ROT_ARB -- requirements
Module: rot_arb

Interface
REQ-001 Parameter N, default 2048, rotation width in bits; SHALL be a power of two.
REQ-002 Parameter log2_N, default 11, SHALL equal log2(N); amount width.
REQ-003 Parameter NREQ, default 4, number of requesters, 2..8.
REQ-004 Parameter IDW, default 2, requester-ID width, SHALL satisfy 2^IDW >= NREQ.
REQ-005 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 req_valid  input  NREQ  per-requester request valid; bit r belongs to requester r.
REQ-008 req_ready  output  NREQ  per-requester accept strobe; one-hot or zero.
REQ-009 req_bits  input  NREQ*N  operand, requester r in slice [r*N +: N]; within a slice, index 0 is the leftmost bit.
REQ-010 req_k  input  NREQ*log2_N  rotate amount, requester r in slice [r*log2_N +: log2_N], unsigned, index 0 the MSB.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 out_bits  output  N  rotated result, index 0 leftmost.
REQ-014 out_id  output  IDW  ID of the requester that owns out_bits.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 Single shared rotator; one transaction in flight; states IDLE, ROT, OUT.
REQ-017 IDLE: if any req_valid is set, grant the first set bit at or after rr_ptr (wrapping modulo NREQ), assert that bit of req_ready in the same cycle, capture its bits, k and ID into holding registers, and go to ROT.
REQ-018 req_ready SHALL be zero outside IDLE and zero in IDLE when no req_valid is set; it is combinational from state, rr_ptr and req_valid.
REQ-019 A handshake on requester r completes in a cycle where req_valid[r] and req_ready[r] are both high.
REQ-020 On a grant, rr_ptr SHALL become (granted index + 1) mod NREQ.
REQ-021 ROT: register the rotated value into out_bits, set out_valid, go to OUT; out_bits[i] = held_bits[(i - k) mod N] for i in 0..N-1, i.e. a rotate toward higher index by k.
REQ-022 The rotator SHALL be built as log2_N cascaded mux stages; stage s is controlled by k[s] and shifts by N >> (s+1).
REQ-023 OUT: hold out_valid, out_bits and out_id stable until out_ready is high; on out_ready, clear out_valid and go to IDLE.
REQ-024 Latency: handshake in cycle t gives out_valid in cycle t+2. With out_ready held high, the next grant occurs at t+3, giving a 3-cycle issue interval.
REQ-025 k = 0 SHALL return the operand unchanged; k = N-1 is a left rotate by 1.
REQ-026 A requester that drops req_valid before it is granted is never granted; no request is queued.
REQ-027 A req_valid change while the block is not in IDLE SHALL have no effect on the transaction in flight.

Reset
REQ-028 When rst_n is low at a clock edge: state becomes IDLE, rr_ptr = 0, out_valid = 0, out_bits = 0, out_id = 0, busy = 0.
REQ-029 Reset asserted in ROT or OUT SHALL discard the transaction; no out_valid pulse follows reset.
REQ-030 req_ready SHALL be 0 in any cycle where rst_n is low.

Verification (N=8, log2_N=3, NREQ=4)
REQ-031 Requester 0 sends bits=10000000, k=001, out_ready=1: handshake at t, out_valid at t+2 with out_bits=01000000, out_id=0.
REQ-032 Requester 2 sends bits=11000001, k=100 -> out_bits=00011100; with k=111 -> out_bits=10000011; with k=000 -> unchanged.
REQ-033 Requesters 0..3 hold req_valid high continuously with rr_ptr=0 -> grants occur in order 0,1,2,3,0 at 3-cycle spacing.
REQ-034 out_ready held low for 5 cycles in OUT -> out_valid, out_bits and out_id stay stable, busy=1, req_ready=0; out_ready=1 -> IDLE on the next cycle.
REQ-035 rst_n pulsed low during ROT -> next cycle: out_valid=0, busy=0, rr_ptr=0; no stale result appears.
